bus_select_reg: RTL and testbench
=================================

// Module: bus_select_reg
// PURPOSE
// - Registered N-source bus selector for the datapath; next generation of the one-hot bus mux.
// - Captures the source picked by a one-hot select into an output register.
// - Uses a valid/ready handshake on both sides and flags malformed selects.
// - Sits between the register file / DIN / PC / G sources and the shared processor bus.
// PARAMETERS
// - WIDTH    16  bus width in bits; narrower sources (e.g. PC) are zero-extended by the caller
// - NSRC     10  number of sources; sel bit i picks src slice i
// - ERR_W     8  width of the saturating error counter
// PORTS
// - clock     in   1            single clock; all state updates on rising edge
// - reset     in   1            synchronous, active-high reset
// - src_flat  in   NSRC*WIDTH   packed sources; source i = src_flat[i*WIDTH +: WIDTH]
// - sel       in   NSRC         one-hot source select
// - in_valid  in   1            sel/src are valid this cycle
// - in_ready  out  1            block can accept; = !out_valid | out_ready (combinational)
// - bus_out   out  WIDTH        registered selected source
// - out_valid out  1            bus_out holds an unconsumed value
// - out_ready in   1            consumer takes bus_out this cycle
// - sel_err   out  1            sticky: a malformed select was accepted
// - err_cnt   out  ERR_W        saturating count of malformed selects accepted
// BEHAVIOUR
// - Reset (sync, high): bus_out=0, out_valid=0, sel_err=0, err_cnt=0; any in-flight word is dropped.
// - Accept = in_valid & in_ready. On accept with exactly one sel bit set:
//   - bus_out <= source i; out_valid <= 1 next cycle; latency 1 clock.
// - Malformed select = sel==0 or more than one bit set (default build):
//   - On accept: bus_out and out_valid unchanged (the word is discarded).
//   - sel_err <= 1; err_cnt increments and saturates at 2**ERR_W-1.
// - Consume = out_valid & out_ready. Consume without accept: out_valid <= 0; bus_out held.
// - Consume and good accept in the same cycle: new word loaded, out_valid stays 1; full throughput.
// - out_valid=1 & out_ready=0: in_ready=0; bus_out stable until consumed.
// - Sources are sampled at the accept edge only.
//   - Source changes while the output is held do not alter bus_out.
//   - This fixes stale-data behaviour: the output never depends on sensitivity to sel alone.
// - sel_err and err_cnt are cleared only by reset.
// - in_valid=0: sel and src are ignored; no error is counted.
// CONFIGURATION
// - BUS_SEL_PRIORITY_EN defined:
//   - Multi-hot sel resolves to the lowest set index and is treated as a good select.
//   - Only sel==0 is malformed.
// - BUS_SEL_PRIORITY_EN undefined: the default build above; multi-hot is an error.
// STRUCTURE
// - Shared package bus_pkg:
//   - BUS_WIDTH default 16.
//   - Source index constants: SRC_DIN=0, SRC_R0..SRC_R6=1..7, SRC_PC=8, SRC_G=9.
//   - Function onehot_ok(sel), returns 1 when exactly one bit of sel is set.
// - Sub-module bus_sel_decode (combinational):
//   - Converts sel to an index plus good flag; priority or strict mode depends on the macro.
//   - The top level holds the output register, handshake logic and error counter.
// TESTING
// - Reset, then sel=10'b0000000001 (src0=16'hA5A5), in_valid=1, out_ready=1:
//   bus_out=16'hA5A5 and out_valid=1 one cycle later.
// - Back-to-back accepts of src3=16'h0003 then src9=16'h0009 with out_ready=1:
//   out_valid stays high two cycles, bus_out is 0003 then 0009.
// - Hold out_ready=0 after one capture: in_ready=0; change src0 to 16'hFFFF; bus_out stays 16'hA5A5.
// - sel=0 with in_valid=1:
//   sel_err=1 and err_cnt=1; bus_out and out_valid unchanged.
// - sel=10'b0000000110 (src1=16'h1111): default build gives sel_err=1 and err_cnt+1.
//   With BUS_SEL_PRIORITY_EN it gives bus_out=16'h1111 and no error.
// - ERR_W=2, five malformed selects: err_cnt saturates at 3.
//   Assert reset while out_valid=1: next cycle all outputs are 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and helpers for the processor bus selector.
// Source index map, default bus width and the one-hot legality check.
package bus_pkg;

    localparam int unsigned BUS_WIDTH = 16;
    localparam int unsigned BUS_NSRC  = 10;

    // Source slots on the shared bus, matching sel bit positions.
    localparam int unsigned SRC_DIN = 0;
    localparam int unsigned SRC_R0  = 1;
    localparam int unsigned SRC_R1  = 2;
    localparam int unsigned SRC_R2  = 3;
    localparam int unsigned SRC_R3  = 4;
    localparam int unsigned SRC_R4  = 5;
    localparam int unsigned SRC_R5  = 6;
    localparam int unsigned SRC_R6  = 7;
    localparam int unsigned SRC_PC  = 8;
    localparam int unsigned SRC_G   = 9;

    // Widest select vector onehot_ok can judge; callers zero-extend into it.
    localparam int unsigned SEL_MAX = 64;

    typedef logic [SEL_MAX-1:0] sel_vec_t;

    function automatic logic onehot_ok(input sel_vec_t sel);
        logic nonzero;
        logic single;
        nonzero = (sel != '0);
        single  = ((sel & (sel - sel_vec_t'(1))) == '0);
        return nonzero && single;
    endfunction

endpackage

// File: rtl/bus_sel_decode.sv
// Combinational select decoder: turns a select vector into a source index and a good flag.
// BUS_SEL_PRIORITY_EN: multi-hot resolves to the lowest set bit instead of being rejected.
module bus_sel_decode
    import bus_pkg::*;
#(
    parameter int unsigned NSRC  = BUS_NSRC,
    parameter int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  sel,
    output logic [IDX_W-1:0] idx,
    output logic             good
);

    logic any_set;

    assign any_set = |sel;

    // Descending scan leaves the lowest set index; for a legal one-hot that is the only bit.
    always_comb begin
        idx = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

`ifdef BUS_SEL_PRIORITY_EN
    assign good = any_set;
`else
    logic strict_ok;

    assign strict_ok = onehot_ok(sel_vec_t'(sel));
    assign good      = any_set & strict_ok;
`endif

endmodule

// File: rtl/bus_select_reg.sv
// Registered one-hot bus selector with valid/ready handshake and malformed-select tracking.
// Select legality comes from bus_sel_decode, which honours BUS_SEL_PRIORITY_EN.
module bus_select_reg
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned NSRC  = BUS_NSRC,
    parameter int unsigned ERR_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_flat,
    input  logic [NSRC-1:0]       sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] src_arr [NSRC];
    logic [IDX_W-1:0] sel_idx;
    logic             sel_good;
    logic [WIDTH-1:0] src_pick;

    logic             accept;
    logic             good_accept;
    logic             bad_accept;
    logic             consume;
    logic             err_full;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_arr[g] = src_flat[g*WIDTH +: WIDTH];
    end

    bus_sel_decode #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_decode (
        .sel  (sel),
        .idx  (sel_idx),
        .good (sel_good)
    );

    assign src_pick = src_arr[sel_idx];

    // Ready only depends on output state, so it never combinationally loops back to in_valid.
    assign in_ready    = ~valid_q | out_ready;
    assign accept      = in_valid & in_ready;
    assign good_accept = accept & sel_good;
    assign bad_accept  = accept & ~sel_good;
    assign consume     = valid_q & out_ready;
    assign err_full    = (cnt_q == {ERR_W{1'b1}});

    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q;
        if (good_accept) begin
            bus_d   = src_pick;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (bad_accept) begin
            err_d = 1'b1;
            if (!err_full) begin
                cnt_d = cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_out   = bus_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_bus_select_reg.sv
// Directed bench for bus_select_reg; a second instance with ERR_W=2 covers counter saturation.
// Expectations for multi-hot selects follow BUS_SEL_PRIORITY_EN.
module tb_bus_select_reg;

    localparam int unsigned W = 16;
    localparam int unsigned N = 10;

    logic           clock;
    logic           reset;
    logic [N*W-1:0] src_flat;
    logic [N-1:0]   sel;
    logic           in_valid;
    logic           out_ready;

    logic           in_ready;
    logic [W-1:0]   bus_out;
    logic           out_valid;
    logic           sel_err;
    logic [7:0]     err_cnt;

    logic           in_ready2;
    logic [W-1:0]   bus_out2;
    logic           out_valid2;
    logic           sel_err2;
    logic [1:0]     err_cnt2;

    int checks;
    int errors;
    int exp_err;

    bus_select_reg #(.WIDTH(W), .NSRC(N), .ERR_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_flat  (src_flat),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_out   (bus_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    bus_select_reg #(.WIDTH(W), .NSRC(N), .ERR_W(2)) dut2 (
        .clock     (clock),
        .reset     (reset),
        .src_flat  (src_flat),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .bus_out   (bus_out2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .sel_err   (sel_err2),
        .err_cnt   (err_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        src_flat[i*W +: W] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = '0;
        src_flat = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus_out !== 16'h0000) begin errors++; $display("FAIL reset_bus got %h want 0000", bus_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_capture();
        set_src(0, 16'hA5A5);
        sel = 10'b0000000001;
        in_valid = 1'b1;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_pre_valid got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL cap_bus got %h want a5a5", bus_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b want 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_consumed_valid got %b want 0", out_valid); end
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL cap_consumed_bus got %h want a5a5", bus_out); end
    endtask

    task automatic test_back_to_back();
        set_src(3, 16'h0003);
        set_src(9, 16'h0009);
        out_ready = 1'b1;
        in_valid = 1'b1;
        sel = 10'b0000001000;
        tick();
        checks++; if (bus_out !== 16'h0003) begin errors++; $display("FAIL b2b_first_bus got %h want 0003", bus_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        sel = 10'b1000000000;
        tick();
        in_valid = 1'b0;
        checks++; if (bus_out !== 16'h0009) begin errors++; $display("FAIL b2b_second_bus got %h want 0009", bus_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %b want 0", out_valid); end
    endtask

    task automatic test_hold();
        set_src(0, 16'hA5A5);
        sel = 10'b0000000001;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL hold_load_bus got %h want a5a5", bus_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
        set_src(0, 16'hFFFF);
        tick();
        tick();
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL hold_stable_bus got %h want a5a5", bus_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_stable_valid got %b want 1", out_valid); end
        // Malformed select offered while stalled is not accepted, so nothing is counted.
        sel = '0;
        tick();
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL hold_no_err got %b want 0", sel_err); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b want 0", out_valid); end
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL hold_release_bus got %h want a5a5", bus_out); end
    endtask

    task automatic test_sel_zero();
        sel = '0;
        in_valid = 1'b0;
        tick();
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL idle_err_cnt got %0d want 0", err_cnt); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_err = 1;
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL zero_sel_err got %b want 1", sel_err); end
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL zero_err_cnt got %0d want %0d", err_cnt, exp_err); end
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL zero_bus got %h want a5a5", bus_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b want 0", out_valid); end
    endtask

    task automatic test_multi_hot();
        set_src(1, 16'h1111);
        set_src(2, 16'h2222);
        sel = 10'b0000000110;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
`ifdef BUS_SEL_PRIORITY_EN
        checks++; if (bus_out !== 16'h1111) begin errors++; $display("FAIL multi_bus got %h want 1111", bus_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL multi_valid got %b want 1", out_valid); end
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL multi_err_cnt got %0d want %0d", err_cnt, exp_err); end
        out_ready = 1'b1;
        tick();
`else
        exp_err++;
        checks++; if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL multi_bus got %h want a5a5", bus_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_valid got %b want 0", out_valid); end
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL multi_err_cnt got %0d want %0d", err_cnt, exp_err); end
`endif
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL multi_sel_err got %b want 1", sel_err); end
        out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        int exp2;
        sel = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_err++;
            exp2 = (exp_err > 3) ? 3 : exp_err;
            checks++; if (err_cnt2 !== 2'(exp2)) begin errors++; $display("FAIL sat_cnt2_%0d got %0d want %0d", k, err_cnt2, exp2); end
        end
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL sat_cnt8 got %0d want %0d", err_cnt, exp_err); end
        checks++; if (sel_err2 !== 1'b1) begin errors++; $display("FAIL sat_sel_err2 got %b want 1", sel_err2); end
    endtask

    task automatic test_reset_midflight();
        set_src(5, 16'h5A5A);
        sel = 10'b0000100000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        checks++; if (bus_out !== 16'h0000) begin errors++; $display("FAIL rst_bus got %h want 0000", bus_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
        checks++; if (err_cnt2 !== 2'd0) begin errors++; $display("FAIL rst_err_cnt2 got %0d want 0", err_cnt2); end
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rst_valid2 got %b want 0", out_valid2); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_err = 0;
        test_reset();
        test_single_capture();
        test_back_to_back();
        test_hold();
        test_sel_zero();
        test_multi_hot();
        test_saturation();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
